// File: rtl/mac_inverse_div.sv
// mac_inverse_div: sequential inverse of the Sobel multiply-accumulate stage.
// Recovers q = (p - c) / b and r = (p - c) % b with a radix-2 restoring
// divider that produces one quotient bit per enabled cycle. Requests use a
// start/busy/done handshake.
// Optional feature: define MID_FRAC_EN for fixed-point mode. In that mode the
// dividend is (p - c) << Q and the iteration count becomes N+Q.
module mac_inverse_div #(
    parameter int N = 16,
    parameter int Q = 12
) (
    input  logic         clk,
    input  logic         sclr_n,
    input  logic         ce,
    input  logic         start,
    input  logic [N-1:0] p,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic         uf
);

`ifdef MID_FRAC_EN
    localparam bit FRAC_EN = 1'b1;
`else
    localparam bit FRAC_EN = 1'b0;
`endif
    // Number of fractional bits appended to the dividend (0 in integer mode).
    localparam int FB = FRAC_EN ? Q : 0;
    // One iteration per dividend bit.
    localparam int K  = N + FB;
    localparam int CW = $clog2(K + 1);
    // Partial remainder is one bit wider than b so the trial subtract never overflows.
    localparam int RW = N + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [K-1:0]  div_q, div_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          uf_q, uf_d;

    // Operand difference; only meaningful in the accept cycle.
    logic [N-1:0] diff;
    assign diff = p - c;

    // One restoring-division step: shift in the next dividend bit, then trial-subtract b.
    logic [RW:0]   rem_sh;
    logic [RW:0]   b_ext;
    logic          ge;
    logic [RW-1:0] rem_nx;
    logic [K-1:0]  div_nx;
    assign rem_sh = {rem_q, div_q[K-1]};
    assign b_ext  = {2'b00, b_q};
    assign ge     = rem_sh >= b_ext;
    assign rem_nx = RW'(ge ? rem_sh - b_ext : rem_sh);
    // The dividend register doubles as the quotient: each freed low bit takes a quotient bit.
    assign div_nx = {div_q[K-2:0], ge};

    // Next-state and datapath control; nothing moves unless ce is high.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        rem_d   = rem_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        uf_d    = uf_q;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        b_d   = b;
                        div_d = K'(diff) << FB;
                        rem_d = '0;
                        cnt_d = CW'(K);
                        if (c > p) begin
                            // Underflow wins over divide-by-zero.
                            state_d = S_DONE;
                            q_d     = '0;
                            r_d     = '0;
                            dz_d    = 1'b0;
                            uf_d    = 1'b1;
                        end else if (b == '0) begin
                            state_d = S_DONE;
                            q_d     = '1;
                            r_d     = diff;
                            dz_d    = 1'b1;
                            uf_d    = 1'b0;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    div_d = div_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // Last step: capture the result so it is valid during the done cycle.
                        state_d = S_DONE;
                        q_d     = N'(div_nx);
                        r_d     = N'(rem_nx);
                        dz_d    = 1'b0;
                        uf_d    = 1'b0;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            uf_q    <= uf_d;
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;
    assign uf   = uf_q;
    assign busy = (state_q == S_RUN);
    // done marks a single enabled cycle; a stalled DONE state does not repeat the pulse.
    assign done = (state_q == S_DONE) && ce;

endmodule

// File: tb/tb_mac_inverse_div.sv
// Self-checking bench for mac_inverse_div.
// It applies a table of directed vectors, then hand-written sequences for
// stalls, back-to-back requests, a stalled done cycle and reset mid-operation.
// It finishes with randomized requests compared against an arithmetic model.
module tb_mac_inverse_div;

    localparam int N = 16;
`ifdef MID_FRAC_EN
    localparam int FB = 12;
`else
    localparam int FB = 0;
`endif
    localparam int K = N + FB;

    logic          clk = 1'b0;
    logic          sclr_n;
    logic          ce;
    logic          start;
    logic [N-1:0]  p, b, c;
    logic [N-1:0]  q, r;
    logic          busy, done, dz, uf;

    int checks = 0;
    int errors = 0;

    mac_inverse_div #(.N(N), .Q(12)) dut (
        .clk    (clk),
        .sclr_n (sclr_n),
        .ce     (ce),
        .start  (start),
        .p      (p),
        .b      (b),
        .c      (c),
        .q      (q),
        .r      (r),
        .busy   (busy),
        .done   (done),
        .dz     (dz),
        .uf     (uf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] p, b, c, q, r;
        logic         dz, uf;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [N-1:0] vp, vb, vc, vq, vr, input logic vdz, vuf, input int vlat);
        vec_t v;
        v.p = vp; v.b = vb; v.c = vc; v.q = vq; v.r = vr;
        v.dz = vdz; v.uf = vuf; v.lat = vlat;
        vecs.push_back(v);
    endtask

    // Reference: straight arithmetic on the operation's definition.
    task automatic model(input logic [N-1:0] mp, mb, mc,
                         output logic [N-1:0] mq, mr, output logic mdz, muf, output int mlat);
        longint unsigned d, dvd;
        if (mc > mp) begin
            mq = '0; mr = '0; mdz = 1'b0; muf = 1'b1; mlat = 1;
        end else begin
            d = longint'(mp) - longint'(mc);
            muf = 1'b0;
            if (mb == '0) begin
                mq = '1; mr = N'(d); mdz = 1'b1; mlat = 1;
            end else begin
                dvd = d << FB;
                mq = N'(dvd / longint'(mb));
                mr = N'(dvd % longint'(mb));
                mdz = 1'b0;
                mlat = K + 1;
            end
        end
    endtask

    // Issue one request, wait (bounded) for done, return what was seen in the done cycle.
    // With stall set, ce drops for 5 cycles mid-run while extra starts are offered.
    task automatic run_op(input logic [N-1:0] vp, vb, vc, input bit stall,
                          output int n, output logic [N-1:0] oq, orr,
                          output logic odz, ouf, obusy, output bit gap);
        p = vp; b = vb; c = vc; start = 1'b1;
        tick();
        start = 1'b0;
        p = N'($urandom); b = N'($urandom); c = N'($urandom);
        n = 1;
        gap = 1'b0;
        while (!done && n < 200) begin
            if (!busy) gap = 1'b1;
            if (stall && n == 3) begin
                start = 1'b1;
                ce = 1'b0;
                repeat (5) begin
                    tick();
                    n++;
                    if (done || !busy) gap = 1'b1;
                end
                ce = 1'b1;
                tick();
                n++;
                start = 1'b0;
            end else begin
                tick();
                n++;
            end
        end
        oq = q; orr = r; odz = dz; ouf = uf; obusy = busy;
        tick();
        check("done_drop", {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int n, elat;
        logic [N-1:0] aq, ar, eq, er;
        logic adz, auf, abusy, edz, euf;
        bit gap;

        sclr_n = 1'b0; ce = 1'b1; start = 1'b0; p = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", dz, 0);
        check("rst_uf", uf, 0);
        #2 sclr_n = 1'b1;
        tick();

        // Directed vectors: p, b, c, q, r, dz, uf, latency
`ifdef MID_FRAC_EN
        add_vec(16'h3000, 16'h2000, 16'h1000, 16'h1000, 16'h0000, 1'b0, 1'b0, 29);
        add_vec(16'd1,    16'd3,    16'd0,    16'd1365, 16'd1,    1'b0, 1'b0, 29);
        add_vec(16'h8000, 16'd1,    16'd0,    16'h0000, 16'h0000, 1'b0, 1'b0, 29);
        add_vec(16'd50,   16'd0,    16'd10,   16'hFFFF, 16'd40,   1'b1, 1'b0, 1);
        add_vec(16'd3,    16'd0,    16'd9,    16'd0,    16'd0,    1'b0, 1'b1, 1);
`else
        add_vec(16'd100,  16'd7,    16'd4,    16'd13,   16'd5,    1'b0, 1'b0, 17);
        add_vec(16'd50,   16'd0,    16'd10,   16'hFFFF, 16'd40,   1'b1, 1'b0, 1);
        add_vec(16'd3,    16'd2,    16'd9,    16'd0,    16'd0,    1'b0, 1'b1, 1);
        add_vec(16'd3,    16'd0,    16'd9,    16'd0,    16'd0,    1'b0, 1'b1, 1);
        add_vec(16'hFFFF, 16'd1,    16'd0,    16'hFFFF, 16'd0,    1'b0, 1'b0, 17);
        add_vec(16'd5,    16'd7,    16'd5,    16'd0,    16'd0,    1'b0, 1'b0, 17);
        add_vec(16'hFFFF, 16'hFFFF, 16'd0,    16'd1,    16'd0,    1'b0, 1'b0, 17);
        add_vec(16'd1234, 16'hFFFF, 16'd0,    16'd0,    16'd1234, 1'b0, 1'b0, 17);
        add_vec(16'd0,    16'd0,    16'd0,    16'hFFFF, 16'd0,    1'b1, 1'b0, 1);
`endif
        foreach (vecs[i]) begin
            run_op(vecs[i].p, vecs[i].b, vecs[i].c, 1'b0, n, aq, ar, adz, auf, abusy, gap);
            check($sformatf("vec%0d_q", i), aq, vecs[i].q);
            check($sformatf("vec%0d_r", i), ar, vecs[i].r);
            check($sformatf("vec%0d_dz", i), adz, vecs[i].dz);
            check($sformatf("vec%0d_uf", i), auf, vecs[i].uf);
            check($sformatf("vec%0d_lat", i), n, vecs[i].lat);
            check($sformatf("vec%0d_busy_done", i), abusy, 0);
            check($sformatf("vec%0d_busy_gap", i), gap, 0);
        end

        // ce low for 5 cycles mid-run, plus starts offered while busy: completion slips by 5.
        run_op(16'd1000, 16'd10, 16'd0, 1'b1, n, aq, ar, adz, auf, abusy, gap);
        model(16'd1000, 16'd10, 16'd0, eq, er, edz, euf, elat);
        check("stall_lat", n, elat + 6 - 1);
        check("stall_q", aq, eq);
        check("stall_r", ar, er);
        check("stall_busy_gap", gap, 0);

        // Back-to-back: start held through the done cycle is ignored there, accepted next cycle.
        p = 16'd200; b = 16'd9; c = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin tick(); n++; end
        model(16'd200, 16'd9, 16'd2, eq, er, edz, euf, elat);
        check("b2b_first_lat", n, elat);
        check("b2b_first_q", q, eq);
        p = 16'd77; b = 16'd5; c = 16'd0; start = 1'b1;
        tick();
        check("b2b_done_start_ignored", {busy, done}, 2'b00);
        tick();
        start = 1'b0;
        check("b2b_accept", busy, 1);
        n = 1;
        while (!done && n < 200) begin tick(); n++; end
        model(16'd77, 16'd5, 16'd0, eq, er, edz, euf, elat);
        check("b2b_second_lat", n, elat);
        check("b2b_second_q", q, eq);
        check("b2b_second_r", r, er);
        tick();

        // ce low while in DONE: done stays low until the enabled cycle, and only that one.
        p = 16'd9; b = 16'd0; c = 16'd4; start = 1'b1;
        ce = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; ce = 1'b0;
        #1 check("ce_low_done_suppressed", done, 0);
        tick();
        check("ce_low_done_held_off", done, 0);
        ce = 1'b1;
        #1 check("ce_high_done_pulse", {done, dz, r}, {1'b1, 1'b1, 16'd5});
        tick();
        check("ce_high_done_once", done, 0);

        // Reset mid-operation: outputs clear asynchronously, then a fresh request still works.
        p = 16'd60000; b = 16'd3; c = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2 sclr_n = 1'b0;
        #1 check("rst_mid_async", {q, r, busy, done, dz, uf}, 0);
        tick();
        check("rst_mid_hold", {q, r, busy, done, dz, uf}, 0);
        sclr_n = 1'b1;
        tick();
        check("rst_mid_idle", {busy, done}, 2'b00);
        run_op(16'd4321, 16'd17, 16'd21, 1'b0, n, aq, ar, adz, auf, abusy, gap);
        model(16'd4321, 16'd17, 16'd21, eq, er, edz, euf, elat);
        check("rst_after_q", aq, eq);
        check("rst_after_r", ar, er);
        check("rst_after_lat", n, elat);

        // Randomized requests against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] rp, rb, rc;
            int sel;
            rp  = N'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0)     rb = '0;
            else if (sel < 4) rb = N'($urandom_range(1, 15));
            else              rb = N'($urandom);
            if ($urandom_range(0, 1) == 0) rc = N'($urandom_range(0, int'(rp)));
            else                           rc = N'($urandom);
            run_op(rp, rb, rc, 1'b0, n, aq, ar, adz, auf, abusy, gap);
            model(rp, rb, rc, eq, er, edz, euf, elat);
            check($sformatf("rnd%0d_q", i), aq, eq);
            check($sformatf("rnd%0d_r", i), ar, er);
            check($sformatf("rnd%0d_flags", i), {adz, auf}, {edz, euf});
            check($sformatf("rnd%0d_lat", i), n, elat);
            check($sformatf("rnd%0d_busy_gap", i), gap, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
